random_code_gen: RTL and testbench
==================================

RANDOM_CODE_GEN -- requirements
Module: random_code_gen

Interface
REQ-001 The block SHALL have parameter SEED, default 8'hA5, the nonzero LFSR reload value.
REQ-002 The block SHALL have parameter DELAY_BASE, default 16'd1000, the fixed part of the delay in tick units.
REQ-003 The block SHALL have parameter DELAY_STEP, default 16'd250, the added delay per code count in tick units.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock, all state on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request for a new random code and delay.
REQ-007 The block SHALL have port tick, input, 1 bit, a one-cycle time-unit enable (1 ms strobe).
REQ-008 The block SHALL have port code, output, 3 bits, the captured random code for the 7-segment code decoder.
REQ-009 The block SHALL have port code_valid, output, 1 bit, high while code holds a captured value.
REQ-010 The block SHALL have port busy, output, 1 bit, high in states ARM and WAIT.
REQ-011 The block SHALL have port go, output, 1 bit, a one-cycle pulse when the delay expires.

Function
REQ-012 The LFSR SHALL be 8-bit Fibonacci (x^8+x^6+x^5+x^4+1), shift left every clk cycle, and insert new bit0 = l[7]^l[5]^l[4]^l[3] (period 255).
REQ-013 If the LFSR value is 8'h00, it SHALL reload SEED on the next cycle instead of shifting.
REQ-014 The FSM SHALL have four states: IDLE, ARM, WAIT and DONE.
REQ-015 In IDLE with start=1, the FSM SHALL capture code<=lfsr[2:0] and go to ARM the next cycle.
REQ-016 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-017 ARM SHALL last exactly 1 cycle, load the 16-bit counter with DELAY_BASE + code*DELAY_STEP, set code_valid=1, and go to WAIT.
REQ-018 The load arithmetic SHALL be 16-bit unsigned, the product 3x16 truncated to 16 bits, and the sum wrapping modulo 2^16.
REQ-019 In WAIT, each cycle with tick=1 SHALL decrement the counter.
REQ-020 When the counter is 1 and tick=1, WAIT SHALL go to DONE.
REQ-021 If the loaded counter value is 0, WAIT SHALL go to DONE on the first tick.
REQ-022 DONE SHALL assert go for exactly 1 cycle, then return to IDLE.
REQ-023 code and code_valid SHALL hold through IDLE until the next accepted start.
REQ-024 start during ARM, WAIT or DONE SHALL be ignored, with no queuing.
REQ-025 tick in IDLE, ARM or DONE SHALL have no effect.
REQ-026 Simultaneous start and tick in IDLE SHALL act as start only.

Reset
REQ-027 Asserting rst_n=0 SHALL, at any time including mid-WAIT, immediately force: state=IDLE, lfsr=SEED, counter=0, code=3'b000, code_valid=0, busy=0, go=0.
REQ-028 After rst_n deasserts, the first LFSR shift SHALL occur on the first rising clk edge.

Configuration
REQ-029 With macro RANDOM_CODE_GEN_ABORT_EN defined, the block SHALL add input abort (1 bit).
REQ-030 With RANDOM_CODE_GEN_ABORT_EN defined, abort=1 in ARM or WAIT SHALL go to IDLE next cycle with no go pulse, clear code_valid, and keep code.
REQ-031 With RANDOM_CODE_GEN_ABORT_EN defined, abort SHALL take priority over tick expiry in the same cycle, and SHALL be ignored in IDLE and DONE.
REQ-032 Without RANDOM_CODE_GEN_ABORT_EN, the abort port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Reset test: rst_n=0 then release -> code=0, code_valid=0, busy=0, go=0; lfsr goes A5 then 4A after 1 clk.
REQ-034 Delay test: DELAY_BASE=4, DELAY_STEP=2, force lfsr[2:0]=3, pulse start -> code=3, busy for ARM plus 10 ticks, go pulses exactly once, 1 cycle after the 10th tick.
REQ-035 Re-trigger test: start pulses every cycle during WAIT -> code unchanged and exactly one go.
REQ-036 Mid-run reset test: rst_n=0 during WAIT with 5 ticks remaining -> no go pulse, all outputs at reset values, and a later start runs a full delay.
REQ-037 LFSR test: free-run 255 cycles -> lfsr returns to A5 with no 00 visited; force lfsr=00 -> reload A5 next cycle.
REQ-038 Abort test (RANDOM_CODE_GEN_ABORT_EN defined): abort and final tick in the same cycle -> IDLE, go=0, code_valid=0.

Source files
------------

// File: rtl/random_code_gen.sv
// Random 3-bit code generator with an LFSR source and a tick-timed delay ending in a one-cycle go pulse.
// Optional abort input is built only when RANDOM_CODE_GEN_ABORT_EN is defined.
module random_code_gen #(
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter logic [15:0] DELAY_BASE = 16'd1000,
  parameter logic [15:0] DELAY_STEP = 16'd250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
`ifdef RANDOM_CODE_GEN_ABORT_EN
  input  logic       abort,
`endif
  output logic [2:0] code,
  output logic       code_valid,
  output logic       busy,
  output logic       go
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_lfsr;
  logic [15:0] r_cnt;
  logic [2:0]  r_code;
  logic        r_code_valid;
  logic [15:0] w_load;
  logic        w_expire;
  logic        w_fb;

  assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_load   = DELAY_BASE + (16'(r_code) * DELAY_STEP);
  // A zero load expires on the first tick, same as a count of one.
  assign w_expire = tick && (r_cnt <= 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (r_lfsr == 8'h00) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ARM;
      ARM:     w_next = WAIT;
      WAIT:    if (w_expire) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
`ifdef RANDOM_CODE_GEN_ABORT_EN
    if (abort && (r_state == ARM || r_state == WAIT)) w_next = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && start) r_code <= r_lfsr[2:0];
      if (r_state == ARM) begin
        r_cnt        <= w_load;
        r_code_valid <= 1'b1;
      end
      if (r_state == WAIT && tick && r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
`ifdef RANDOM_CODE_GEN_ABORT_EN
      // Abort wins over the ARM-cycle set so an aborted run never looks valid.
      if (abort && (r_state == ARM || r_state == WAIT)) r_code_valid <= 1'b0;
`endif
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign busy       = (r_state == ARM) || (r_state == WAIT);
  assign go         = (r_state == DONE);

endmodule

// File: tb/tb_random_code_gen.sv
// Directed scoreboard bench for random_code_gen: delays, retrigger, mid-run reset, wrap/zero load, LFSR period and reload.
// Define RANDOM_CODE_GEN_ABORT_EN to also exercise the abort path.
module tb_random_code_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       tick = 1'b0;
`ifdef RANDOM_CODE_GEN_ABORT_EN
  logic       abort_i = 1'b0;
`endif
  logic [2:0] code_a, code_b;
  logic       cv_a, cv_b, busy_a, busy_b, go_a, go_b;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  logic [7:0]  m_lfsr;

  typedef struct {
    logic [2:0]  code;
    int unsigned ticks;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  random_code_gen #(.SEED(8'hA5), .DELAY_BASE(16'd4), .DELAY_STEP(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tick(tick),
`ifdef RANDOM_CODE_GEN_ABORT_EN
    .abort(abort_i),
`endif
    .code(code_a), .code_valid(cv_a), .busy(busy_a), .go(go_a)
  );

  // Wrapping instance: code 4 loads 0, code 5 loads 4.
  random_code_gen #(.SEED(8'hA5), .DELAY_BASE(16'hFFF0), .DELAY_STEP(16'h0004)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tick(tick),
`ifdef RANDOM_CODE_GEN_ABORT_EN
    .abort(1'b0),
`endif
    .code(code_b), .code_valid(cv_b), .busy(busy_b), .go(go_b)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              m_lfsr <= 8'hA5;
    else if (m_lfsr == 8'h00) m_lfsr <= 8'hA5;
    else                     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_go(input bit sel);   return sel ? go_b   : go_a;   endfunction
  function automatic logic rd_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
  function automatic logic rd_cv(input bit sel);   return sel ? cv_b   : cv_a;   endfunction
  function automatic logic [2:0] rd_code(input bit sel); return sel ? code_b : code_a; endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"}, code_a, 3'd0);
    chk({tag, "_valid"}, cv_a, 1'b0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_go"}, go_a, 1'b0);
  endtask

  // One job: wait for the wanted code at the LFSR, start, tick until expiry (or abort/reset point).
  task automatic run_job(input bit sel, input logic [2:0] want, input bit retrig,
                         input int unsigned abort_at, input int unsigned reset_left);
    exp_t        e;
    int unsigned d;
    int unsigned ticks;
    logic [15:0] ld;
    bit          found;
    bit          aborted;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_lfsr[2:0] == want) found = 1;
      else @(negedge clk);
    end
    chk("lfsr_sync", found, 1);
    ld = sel ? 16'hFFF0 + 16'(want) * 16'h0004 : 16'd4 + 16'(want) * 16'd2;
    d  = (ld == 16'd0) ? 1 : int'(ld);
    e.code = want;
    e.ticks = d;
    sb.push_back(e);
    // start together with tick in IDLE must act as start
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("arm_busy", rd_busy(sel), 1'b1);
    chk("arm_code", rd_code(sel), want);
    @(negedge clk);  // tick held high through ARM, which must ignore it
    tick = 1'b0;
    chk("wait_valid", rd_cv(sel), 1'b1);
    chk("wait_busy", rd_busy(sel), 1'b1);
    ticks = 0;
    aborted = 0;
    for (int cyc = 0; cyc < 400 && ticks < d && !aborted; cyc++) begin
      if (reset_left != 0 && ticks == d - reset_left) break;
      tick = ($urandom_range(0, 2) != 0);
      if (retrig) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (tick) ticks++;
`ifdef RANDOM_CODE_GEN_ABORT_EN
      if (abort_at != 0 && tick && ticks == abort_at) begin
        abort_i = 1'b1;
        aborted = 1;
      end
`endif
      @(negedge clk);
      tick = 1'b0;
`ifdef RANDOM_CODE_GEN_ABORT_EN
      abort_i = 1'b0;
`endif
      if (ticks < d && !aborted) begin
        chk("run_go", rd_go(sel), 1'b0);
        chk("run_busy", rd_busy(sel), 1'b1);
      end
    end
    if (reset_left != 0) begin
      void'(sb.pop_back());
      rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      repeat (3) begin
        @(negedge clk);
        chk("midreset_nogo", go_a, 1'b0);
      end
      rst_n = 1'b1;
    end else if (aborted) begin
      void'(sb.pop_front());
      chk("abort_go", rd_go(sel), 1'b0);
      chk("abort_busy", rd_busy(sel), 1'b0);
      chk("abort_valid", rd_cv(sel), 1'b0);
      chk("abort_code", rd_code(sel), want);
      @(negedge clk);
      chk("abort_nogo", rd_go(sel), 1'b0);
    end else begin
      chk("budget", ticks >= d, 1);
      chk("done_go", rd_go(sel), 1'b1);
      chk("done_busy", rd_busy(sel), 1'b0);
      start_a = 1'b0; start_b = 1'b0;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_code", rd_code(sel), e.code);
        chk("sb_ticks", ticks, e.ticks);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("post_go", rd_go(sel), 1'b0);
        chk("post_busy", rd_busy(sel), 1'b0);
        chk("hold_valid", rd_cv(sel), 1'b1);
        chk("hold_code", rd_code(sel), want);
      end
    end
  endtask

  initial begin
    int unsigned zeros;
    int unsigned model_err;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_lfsr", dut.r_lfsr, 8'hA5);
    rst_n = 1'b1;
    #1 chk("rel_lfsr", dut.r_lfsr, 8'hA5);
    @(negedge clk);
    chk("first_shift", dut.r_lfsr, 8'h4A);

    run_job(0, 3'd3, 0, 0, 0);   // 4 + 3*2 = 10 ticks
    run_job(0, 3'd7, 0, 0, 0);   // 18 ticks
    run_job(0, 3'd0, 1, 0, 0);   // retrigger every cycle, 4 ticks

    // ticks in IDLE do nothing
    for (int k = 0; k < 4; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("idle_tick_busy", busy_a, 1'b0);
      chk("idle_tick_go", go_a, 1'b0);
    end

    run_job(0, 3'd3, 0, 0, 5);   // reset with 5 ticks left
    run_job(0, 3'd5, 0, 0, 0);   // full 14-tick run afterwards
    run_job(1, 3'd4, 0, 0, 0);   // wrapped load of 0: first tick expires
    run_job(1, 3'd5, 0, 0, 0);   // wrapped load of 4
`ifdef RANDOM_CODE_GEN_ABORT_EN
    run_job(0, 3'd6, 0, 16, 0);  // abort on the final tick
`endif

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    model_err = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (dut.r_lfsr == 8'h00) zeros++;
      if (dut.r_lfsr != m_lfsr) model_err++;
    end
    chk("period_a5", dut.r_lfsr, 8'hA5);
    chk("period_nozero", zeros, 0);
    chk("period_model", model_err, 0);

    force dut.r_lfsr = 8'h00;
    #1 release dut.r_lfsr;
    @(negedge clk);
    chk("zero_reload", dut.r_lfsr, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
